// File: rtl/regf_pkg.sv
// Shared constants and types for the 32 x 32 register file.
// Imported by register_file, regf_read_port and the bench.
package regf_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int REG_ZERO = 0;

   typedef logic [ADDR_W-1:0] regf_addr_t;
   typedef logic [DATA_W-1:0] regf_data_t;

endpackage

// File: rtl/regf_read_port.sv
// One combinational read port: array mux, zero-register forcing
// and, with REGF_BYPASS_EN defined, same-cycle write forwarding.
module regf_read_port #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic [DATA_W-1:0] i_regs [DEPTH],
   input  logic [ADDR_W-1:0] i_addr,
`ifdef REGF_BYPASS_EN
   input  logic              i_wen,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
`endif
   output logic [DATA_W-1:0] o_data
);

   import regf_pkg::*;

   logic w_is_zero;

   assign w_is_zero = (i_addr == ADDR_W'(REG_ZERO));

   // Select stored value, optionally forward the pending write,
   // and let the zero register override everything.
   always_comb begin
      o_data = i_regs[i_addr];
`ifdef REGF_BYPASS_EN
      if (i_wen && (i_waddr == i_addr)) begin
         o_data = i_wdata;
      end
`endif
      if (w_is_zero) begin
         o_data = '0;
      end
   end

endmodule

// File: rtl/register_file.sv
// 32-entry register file, two async read ports, one sync write port.
// Optional write-to-read forwarding when REGF_BYPASS_EN is defined.
module register_file #(
   parameter int DATA_W = regf_pkg::DATA_W,
   parameter int ADDR_W = regf_pkg::ADDR_W,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] addr1,
   output logic [DATA_W-1:0] y1,
   input  logic [ADDR_W-1:0] addr2,
   output logic [DATA_W-1:0] y2
);

   import regf_pkg::*;

   logic [DATA_W-1:0] r_regs [DEPTH];

`ifdef REGF_BYPASS_EN
   logic w_fwd_en;

   // Forward only writes that will really land: not during reset,
   // never to the zero register.
   assign w_fwd_en = sel && !rst
                   && (waddr != ADDR_W'(REG_ZERO));
`endif

   // Clear everything on reset; commit writes except to register 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (sel && (waddr != ADDR_W'(REG_ZERO))) begin
         r_regs[waddr] <= wdata;
      end
   end

   regf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_rd1 (
      .i_regs  (r_regs),
      .i_addr  (addr1),
`ifdef REGF_BYPASS_EN
      .i_wen   (w_fwd_en),
      .i_waddr (waddr),
      .i_wdata (wdata),
`endif
      .o_data  (y1)
   );

   regf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_rd2 (
      .i_regs  (r_regs),
      .i_addr  (addr2),
`ifdef REGF_BYPASS_EN
      .i_wen   (w_fwd_en),
      .i_waddr (waddr),
      .i_wdata (wdata),
`endif
      .o_data  (y2)
   );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: driver pushes expected reads,
// a negedge monitor pops and compares against the DUT outputs.
module tb_register_file;

   import regf_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       sel;
   regf_addr_t waddr;
   regf_data_t wdata;
   regf_addr_t addr1;
   regf_addr_t addr2;
   regf_data_t y1;
   regf_data_t y2;

   always #5 clk = ~clk;

   register_file dut (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel),
      .waddr (waddr),
      .wdata (wdata),
      .addr1 (addr1),
      .y1    (y1),
      .addr2 (addr2),
      .y2    (y2)
   );

   typedef struct {
      regf_addr_t a1;
      regf_addr_t a2;
      regf_data_t y1;
      regf_data_t y2;
   } exp_t;

   exp_t       exp_q [$];
   exp_t       m_e;
   regf_data_t mem [32];
   int         n_vec = 0;
   int         n_err = 0;

   logic       p_sel;
   logic       p_rst;
   regf_addr_t p_waddr;
   regf_data_t p_wdata;

   // Reference read: zero register first, then reset, then forwarding.
   function automatic regf_data_t model_rd(regf_addr_t a);
      if (a == 0) return '0;
      if (rst) return '0;
`ifdef REGF_BYPASS_EN
      if (sel && waddr != 0 && waddr == a) return wdata;
`endif
      return mem[a];
   endfunction

   // One cycle: retire the write seen at this edge, drive new inputs,
   // queue the reads expected before the next edge.
   task automatic apply(input logic r, input logic s,
                        input regf_addr_t wa, input regf_data_t wd,
                        input regf_addr_t a1, input regf_addr_t a2);
      exp_t e;
      @(posedge clk);
      #1;
      if (p_sel && !p_rst && p_waddr != 0) mem[p_waddr] = p_wdata;
      rst   = r;
      sel   = s;
      waddr = wa;
      wdata = wd;
      addr1 = a1;
      addr2 = a2;
      if (r) begin
         for (int i = 0; i < 32; i++) mem[i] = '0;
      end
      e.a1 = a1;
      e.a2 = a2;
      e.y1 = model_rd(a1);
      e.y2 = model_rd(a2);
      exp_q.push_back(e);
      p_sel   = s;
      p_rst   = r;
      p_waddr = wa;
      p_wdata = wd;
   endtask

   task automatic rand_cycle(input logic r);
      apply(r, 1'($urandom_range(0, 1)),
            regf_addr_t'($urandom), regf_data_t'($urandom),
            regf_addr_t'($urandom), regf_addr_t'($urandom));
   endtask

   // Monitor: compare both ports whenever an expectation is pending.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         m_e = exp_q.pop_front();
         n_vec++;
         if (y1 !== m_e.y1) begin
            n_err++;
            $display("FAIL y1 addr1=%0d got=%h exp=%h",
                     m_e.a1, y1, m_e.y1);
         end
         if (y2 !== m_e.y2) begin
            n_err++;
            $display("FAIL y2 addr2=%0d got=%h exp=%h",
                     m_e.a2, y2, m_e.y2);
         end
      end
   end

   initial begin
      rst     = 1'b1;
      sel     = 1'b0;
      waddr   = '0;
      wdata   = '0;
      addr1   = '0;
      addr2   = '0;
      p_sel   = 1'b0;
      p_rst   = 1'b1;
      p_waddr = '0;
      p_wdata = '0;
      for (int i = 0; i < 32; i++) mem[i] = '0;

      // Reset state; a write held during reset must be dropped.
      apply(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
      apply(1'b1, 1'b1, 5'd3, 32'd55, 5'd3, 5'd5);
      // First edge after reset release accepts the write.
      apply(1'b0, 1'b1, 5'd1, 32'd17, 5'd0, 5'd1);
      apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd1);

      // Sweep: reg[i] = 16 + i.
      for (int i = 1; i < 32; i++) begin
         apply(1'b0, 1'b1, regf_addr_t'(i), regf_data_t'(16 + i),
               regf_addr_t'(i), regf_addr_t'(i - 1));
      end
      for (int i = 0; i < 32; i++) begin
         apply(1'b0, 1'b0, 5'd0, 32'd0,
               regf_addr_t'(i), regf_addr_t'(31 - i));
      end

      // Zero register ignores writes.
      apply(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
      apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

      // sel=0 leaves state alone.
      apply(1'b0, 1'b1, 5'd3, 32'd20, 5'd1, 5'd2);
      apply(1'b0, 1'b0, 5'd3, 32'd99, 5'd3, 5'd3);
      apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);

      // Independent and shared read addresses.
      apply(1'b0, 1'b1, 5'd7, 32'd70, 5'd0, 5'd0);
      apply(1'b0, 1'b1, 5'd9, 32'd90, 5'd0, 5'd0);
      apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd9);
      apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);

      // Same-cycle read/write of reg 4: 10 -> 11.
      apply(1'b0, 1'b1, 5'd4, 32'd10, 5'd0, 5'd0);
      apply(1'b0, 1'b1, 5'd4, 32'd11, 5'd4, 5'd4);
      apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd4);

      repeat (400) rand_cycle(1'b0);

      // Asynchronous reset mid-run, with random writes offered.
      repeat (4) rand_cycle(1'b1);
      apply(1'b0, 1'b1, 5'd12, 32'd123, 5'd12, 5'd0);
      apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd5);

      repeat (150) rand_cycle(1'b0);

      for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the datapath.
- Two combinational read ports and one synchronous write port.
- Sits between the instruction decode stage (read addresses) and writeback (write address/data).
- The clock comes from the shared clock generator block, named Clock, which is outside this block.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, width of each address port.
- DEPTH, 2**ADDR_W (32), number of registers.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sel  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- addr1  input  ADDR_W  read address, port 1.
- y1  output  DATA_W  read data, port 1.
- addr2  input  ADDR_W  read address, port 2.
- y2  output  DATA_W  read data, port 2.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset:
  - rst high clears all DEPTH registers to 0 immediately, without waiting for a clock edge.
  - Any write presented while rst is high is discarded.
  - A write on the first rising edge after rst falls is accepted.
- Write:
  - On the rising edge of clk, if sel=1 and rst=0, reg[waddr] <= wdata.
  - If sel=0, no state changes.
- Register 0:
  - Hardwired to zero.
  - Writes to waddr=0 are ignored.
  - Reads of address 0 always return 0.
- Read:
  - Purely combinational, zero latency: y1 = reg[addr1], y2 = reg[addr2].
  - Outputs follow address changes within the same cycle.
  - After reset, y1 = y2 = 0 for every address.
- Write latency:
  - Data written at edge N is visible on a read port immediately after edge N.
  - Without bypass, a same-cycle read of waddr returns the old value before the edge.
- Both read ports may address the same register, including the write target, simultaneously.
- Addresses are ADDR_W bits, so there is no out-of-range case. Address arithmetic in the surrounding logic wraps 31 -> 0 naturally.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: REGF_BYPASS_EN.
- Defined:
  - Write-to-read forwarding.
  - If sel=1, waddr != 0 and addrN == waddr, then yN = wdata combinationally in the same cycle.
  - Zero-register rule still wins.
- Undefined:
  - No forwarding.
  - yN shows the stored value; new data appears only after the clock edge.

Decomposition:
- Shared package regf_pkg:
  - DATA_W and ADDR_W constants.
  - Typedefs regf_addr_t [ADDR_W-1:0] and regf_data_t [DATA_W-1:0].
  - Constant REG_ZERO = 0.
- One natural sub-module, regf_read_port, instantiated twice:
  - Address mux over the storage array.
  - Zero-register forcing.
  - Optional bypass compare.
- Storage array and write logic stay in register_file.

Test Plan:
- Assert rst, then set addr1 = addr2 = 5 -> y1 = y2 = 0; assert rst mid-run after writes -> all reads return 0 immediately.
- sel=1, waddr=1, wdata=17; on the next edge read addr2=1 -> y2 = 17. Sweep waddr 1..31 with wdata 17..47, incrementing each edge -> each reg[i] reads 16+i.
- sel=1, waddr=0, wdata=32'hDEADBEEF -> addr1=0 reads 0.
- sel=0, waddr=3, wdata=99 after reg[3]=20 -> reg[3] still reads 20.
- addr1=7, addr2=9 after writes 7->70 and 9->90 -> y1=70 and y2=90 simultaneously; addr1 = addr2 = 9 -> both read 90.
- Same-cycle read/write of reg 4, old value 10, new value 11:
  - With REGF_BYPASS_EN -> y1 = 11 before the edge.
  - Without it -> y1 = 10 before the edge, 11 after.
